// File: rtl/result_uart_reporter.sv
// result_uart_reporter
//   Captures an (x, y) match coordinate on a rising edge of valid_in,
//   converts both values to ASCII decimal using double-dabble, and sends
//   the frame "XXXX,YYY" plus a terminator as 8N1 UART on TxD.
//
//   Optional build macro: REPORTER_CRLF_EN
//     defined   -> terminator 0x0D 0x0A (10-byte frame)
//     undefined -> terminator 0x0A only (9-byte frame)
//
//   Parameters:
//     CLK_FREQ  system clock in Hz
//     BAUD      UART bit rate; bit period is CLK_FREQ/BAUD cycles (>= 2)
//
//   Ports:
//     clock     system clock, rising edge
//     notReset  asynchronous active-low reset
//     valid_in  result valid; a rising edge starts a report when idle
//     x_in      x coordinate 0..1023
//     y_in      y coordinate 0..511
//     TxD       UART serial output, idle high
//     busy      high from capture until the last stop bit ends
//     done      one-cycle pulse when the frame is finished
module result_uart_reporter #(
   parameter int unsigned CLK_FREQ = 50000000,
   parameter int unsigned BAUD     = 115200
) (
   input  logic       clock,
   input  logic       notReset,
   input  logic       valid_in,
   input  logic [9:0] x_in,
   input  logic [8:0] y_in,
   output logic       TxD,
   output logic       busy,
   output logic       done
);

   localparam int unsigned DIV = CLK_FREQ / BAUD;
   localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

`ifdef REPORTER_CRLF_EN
   localparam logic [3:0] LAST_BYTE = 4'd9;
`else
   localparam logic [3:0] LAST_BYTE = 4'd8;
`endif

   typedef enum logic [1:0] {IDLE, CONVERT, LOAD, SHIFT} state_t;

   state_t        state_q, state_d;
   logic          valid_prev_q, valid_prev_d;
   logic [9:0]    x_bin_q, x_bin_d;
   logic [15:0]   x_bcd_q, x_bcd_d;
   logic [9:0]    y_bin_q, y_bin_d;
   logic [11:0]   y_bcd_q, y_bcd_d;
   logic [3:0]    conv_cnt_q, conv_cnt_d;
   logic [3:0]    byte_idx_q, byte_idx_d;
   logic [3:0]    bit_idx_q, bit_idx_d;
   logic [CW-1:0] baud_cnt_q, baud_cnt_d;
   logic [9:0]    shreg_q, shreg_d;
   logic          txd_q, txd_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [15:0]   x_adj;
   logic [11:0]   y_adj;
   logic [3:0]    load_idx;
   logic [7:0]    load_byte;

   // add-3 correction on every BCD digit that is 5 or more
   function automatic logic [15:0] adj_x(input logic [15:0] bcd);
      logic [15:0] r;
      r = bcd;
      for (int unsigned i = 0; i < 4; i++) begin
         if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   function automatic logic [11:0] adj_y(input logic [11:0] bcd);
      logic [11:0] r;
      r = bcd;
      for (int unsigned i = 0; i < 3; i++) begin
         if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   assign x_adj = adj_x(x_bcd_q);
   assign y_adj = adj_y(y_bcd_q);

   // The byte to load: the current index when entering from CONVERT,
   // the following index when chaining directly out of a stop bit.
   always_comb begin
      load_idx  = (state_q == LOAD) ? byte_idx_q : byte_idx_q + 4'd1;
      load_byte = 8'h0A;
      case (load_idx)
         4'd0: load_byte = {4'h3, x_bcd_q[15:12]};
         4'd1: load_byte = {4'h3, x_bcd_q[11:8]};
         4'd2: load_byte = {4'h3, x_bcd_q[7:4]};
         4'd3: load_byte = {4'h3, x_bcd_q[3:0]};
         4'd4: load_byte = 8'h2C;
         4'd5: load_byte = {4'h3, y_bcd_q[11:8]};
         4'd6: load_byte = {4'h3, y_bcd_q[7:4]};
         4'd7: load_byte = {4'h3, y_bcd_q[3:0]};
`ifdef REPORTER_CRLF_EN
         4'd8: load_byte = 8'h0D;
         4'd9: load_byte = 8'h0A;
`else
         4'd8: load_byte = 8'h0A;
`endif
         default: load_byte = 8'h0A;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      valid_prev_d = valid_in;
      x_bin_d      = x_bin_q;
      x_bcd_d      = x_bcd_q;
      y_bin_d      = y_bin_q;
      y_bcd_d      = y_bcd_q;
      conv_cnt_d   = conv_cnt_q;
      byte_idx_d   = byte_idx_q;
      bit_idx_d    = bit_idx_q;
      baud_cnt_d   = baud_cnt_q;
      shreg_d      = shreg_q;
      txd_d        = txd_q;
      busy_d       = busy_q;
      done_d       = 1'b0;

      case (state_q)
         IDLE: begin
            txd_d = 1'b1;
            if (valid_in && !valid_prev_q) begin
               x_bin_d    = x_in;
               y_bin_d    = {1'b0, y_in};
               x_bcd_d    = '0;
               y_bcd_d    = '0;
               conv_cnt_d = '0;
               busy_d     = 1'b1;
               state_d    = CONVERT;
            end
         end
         CONVERT: begin
            x_bcd_d    = {x_adj[14:0], x_bin_q[9]};
            x_bin_d    = {x_bin_q[8:0], 1'b0};
            y_bcd_d    = {y_adj[10:0], y_bin_q[9]};
            y_bin_d    = {y_bin_q[8:0], 1'b0};
            conv_cnt_d = conv_cnt_q + 4'd1;
            if (conv_cnt_q == 4'd9) state_d = LOAD;
         end
         LOAD: begin
            shreg_d    = {1'b1, load_byte, 1'b0};
            bit_idx_d  = '0;
            baud_cnt_d = '0;
            txd_d      = 1'b0;
            state_d    = SHIFT;
         end
         SHIFT: begin
            if (baud_cnt_q == CW'(DIV - 1)) begin
               baud_cnt_d = '0;
               if (bit_idx_q == 4'd9) begin
                  if (byte_idx_q == LAST_BYTE) begin
                     done_d     = 1'b1;
                     busy_d     = 1'b0;
                     txd_d      = 1'b1;
                     byte_idx_d = '0;
                     state_d    = IDLE;
                  end else begin
                     // next byte is loaded here rather than via LOAD so the
                     // start bit follows the stop bit with no gap
                     byte_idx_d = byte_idx_q + 4'd1;
                     shreg_d    = {1'b1, load_byte, 1'b0};
                     bit_idx_d  = '0;
                     txd_d      = 1'b0;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
                  txd_d     = shreg_q[bit_idx_q + 4'd1];
               end
            end else begin
               baud_cnt_d = baud_cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge notReset) begin
      if (!notReset) begin
         state_q      <= IDLE;
         valid_prev_q <= 1'b0;
         x_bin_q      <= '0;
         x_bcd_q      <= '0;
         y_bin_q      <= '0;
         y_bcd_q      <= '0;
         conv_cnt_q   <= '0;
         byte_idx_q   <= '0;
         bit_idx_q    <= '0;
         baud_cnt_q   <= '0;
         shreg_q      <= '1;
         txd_q        <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         valid_prev_q <= valid_prev_d;
         x_bin_q      <= x_bin_d;
         x_bcd_q      <= x_bcd_d;
         y_bin_q      <= y_bin_d;
         y_bcd_q      <= y_bcd_d;
         conv_cnt_q   <= conv_cnt_d;
         byte_idx_q   <= byte_idx_d;
         bit_idx_q    <= bit_idx_d;
         baud_cnt_q   <= baud_cnt_d;
         shreg_q      <= shreg_d;
         txd_q        <= txd_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign TxD  = txd_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_result_uart_reporter.sv
// Testbench for result_uart_reporter with CLK_FREQ=1000, BAUD=100 (10 cycles
// per bit). Honours REPORTER_CRLF_EN the same way as the design.
module tb_result_uart_reporter;

   localparam int DIV = 10;
`ifdef REPORTER_CRLF_EN
   localparam int NB      = 10;
   localparam int LIT_END = 1011;
`else
   localparam int NB      = 9;
   localparam int LIT_END = 911;
`endif
   localparam int FRAME_END = 11 + NB * 10 * DIV;

   logic       clock    = 1'b0;
   logic       notReset = 1'b1;
   logic       valid_in = 1'b0;
   logic [9:0] x_in     = '0;
   logic [8:0] y_in     = '0;
   logic       TxD, busy, done;

   always #5 clock = ~clock;

   result_uart_reporter #(.CLK_FREQ(1000), .BAUD(100)) dut (
      .clock    (clock),
      .notReset (notReset),
      .valid_in (valid_in),
      .x_in     (x_in),
      .y_in     (y_in),
      .TxD      (TxD),
      .busy     (busy),
      .done     (done)
   );

   int tests = 0;
   int fails = 0;

   // ---------------- timeline model ----------------
   int m_e = 0, m_n = 0, m_x = 0, m_y = 0;
   bit m_busy = 0, m_prev = 0, m_done = 0;
   bit chk_en = 0;
   int dut_done_cnt = 0;
   int start_e = 0;

   function automatic logic [7:0] exp_byte(int x, int y, int k);
      case (k)
         0: return 8'(48 + x / 1000);
         1: return 8'(48 + (x / 100) % 10);
         2: return 8'(48 + (x / 10) % 10);
         3: return 8'(48 + x % 10);
         4: return 8'h2C;
         5: return 8'(48 + y / 100);
         6: return 8'(48 + (y / 10) % 10);
         7: return 8'(48 + y % 10);
`ifdef REPORTER_CRLF_EN
         8: return 8'h0D;
`endif
         default: return 8'h0A;
      endcase
   endfunction

   // expected line level d edges after capture
   function automatic logic exp_txd(bit bsy, int d, int x, int y);
      int off, bk, bi;
      logic [7:0] b;
      if (!bsy || d < 11) return 1'b1;
      off = d - 11;
      bk  = off / (10 * DIV);
      bi  = (off / DIV) % 10;
      if (bi == 0) return 1'b0;
      if (bi == 9) return 1'b1;
      b = exp_byte(x, y, bk);
      return b[bi-1];
   endfunction

   always @(posedge clock or negedge notReset) begin
      if (!notReset) begin
         m_busy = 0; m_prev = 0; m_done = 0; m_e = 0; m_n = 0;
      end else begin
         m_e++;
         m_done = 0;
         if (m_busy) begin
            if (m_e == m_n + FRAME_END) begin
               m_busy = 0;
               m_done = 1;
            end
         end else if (valid_in && !m_prev) begin
            m_busy = 1;
            m_n    = m_e;
            m_x    = int'(x_in);
            m_y    = int'(y_in);
         end
         m_prev = valid_in;
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         logic et;
         et = exp_txd(m_busy, m_e - m_n, m_x, m_y);
         tests++;
         if (TxD !== et) begin
            fails++; $display("FAIL txd e=%0d got=%b exp=%b", m_e, TxD, et);
         end
         tests++;
         if (busy !== m_busy) begin
            fails++; $display("FAIL busy e=%0d got=%b exp=%b", m_e, busy, m_busy);
         end
         tests++;
         if (done !== m_done) begin
            fails++; $display("FAIL done e=%0d got=%b exp=%b", m_e, done, m_done);
         end
         if (done === 1'b1) dut_done_cnt++;
      end
   end

   // ---------------- UART monitor (mid-bit sampling) ----------------
   logic [7:0] rx_q[$];
   bit         mon_act = 0;
   int         mon_cnt = 0;
   logic [9:0] mon_bits;

   always @(negedge clock) begin
      if (!notReset) begin
         mon_act = 0;
      end else if (!mon_act) begin
         if (TxD === 1'b0) begin
            mon_act = 1;
            mon_cnt = 0;
         end
      end else begin
         mon_cnt++;
         if (mon_cnt % DIV == DIV / 2) begin
            mon_bits[mon_cnt / DIV] = TxD;
            if (mon_cnt / DIV == 9) begin
               tests++;
               if (TxD !== 1'b1) begin
                  fails++; $display("FAIL stop_bit got=%b exp=1", TxD);
               end
               rx_q.push_back(mon_bits[8:1]);
               mon_act = 0;
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", name, got, got, exp, exp);
      end
   endtask

   task automatic check_bytes(input string name, input logic [7:0] e8 [8]);
      logic [7:0] e [10];
      for (int k = 0; k < 8; k++) e[k] = e8[k];
`ifdef REPORTER_CRLF_EN
      e[8] = 8'h0D; e[9] = 8'h0A;
`else
      e[8] = 8'h0A; e[9] = 8'h00;
`endif
      check({name, "_len"}, rx_q.size(), NB);
      for (int k = 0; k < NB && k < rx_q.size(); k++)
         check($sformatf("%s_b%0d", name, k), int'(rx_q[k]), int'(e[k]));
   endtask

   task automatic pulse(input int x, input int y);
      @(negedge clock);
      x_in = 10'(x); y_in = 9'(y); valid_in = 1'b1;
      @(negedge clock);
      valid_in = 1'b0;
      start_e  = m_e;
   endtask

   // returns at the negedge where done is seen (or after the budget)
   task automatic wait_done(output int lat, output int bcyc, output int first_low);
      lat = -1; bcyc = 0; first_low = -1;
      for (int i = 0; i < 3000; i++) begin
         if (busy === 1'b1) bcyc++;
         if (TxD === 1'b0 && first_low < 0) first_low = m_e - start_e;
         if (done === 1'b1) begin
            lat = m_e - start_e;
            break;
         end
         @(negedge clock);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] e [8];
      int lat, bc, fl, d0;

      // reset held with random inputs
      #1 notReset = 1'b0;
      #1 chk_en = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         valid_in = 1'($urandom_range(0, 1));
         x_in = 10'($urandom_range(0, 1023));
         y_in = 9'($urandom_range(0, 511));
         check("rst_txd", int'(TxD), 1);
         check("rst_busy", int'(busy), 0);
      end
      valid_in = 1'b0;
      @(negedge clock) notReset = 1'b1;
      repeat (30) @(negedge clock);
      check("idle_txd", int'(TxD), 1);
      check("idle_busy", int'(busy), 0);

      // x=640 y=480
      rx_q.delete();
      pulse(640, 480);
      wait_done(lat, bc, fl);
      check("f640_lat", lat, LIT_END);
      check("f640_busy", bc, LIT_END);
      check("f640_start", fl, 11);
      e = '{8'h30, 8'h36, 8'h34, 8'h30, 8'h2C, 8'h34, 8'h38, 8'h30};
      check_bytes("f640", e);

      // x=1023 y=511
      rx_q.delete();
      pulse(1023, 511);
      wait_done(lat, bc, fl);
      check("fmax_lat", lat, LIT_END);
      e = '{8'h31, 8'h30, 8'h32, 8'h33, 8'h2C, 8'h35, 8'h31, 8'h31};
      check_bytes("fmax", e);

      // x=0 y=0
      rx_q.delete();
      pulse(0, 0);
      wait_done(lat, bc, fl);
      check("fzero_lat", lat, LIT_END);
      e = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h2C, 8'h30, 8'h30, 8'h30};
      check_bytes("fzero", e);

      // valid_in held high for 2000 cycles -> one frame
      rx_q.delete();
      repeat (5) @(negedge clock);
      d0 = dut_done_cnt;
      x_in = 10'd7; y_in = 9'd8; valid_in = 1'b1;
      repeat (2000) @(negedge clock);
      valid_in = 1'b0;
      repeat (20) @(negedge clock);
      check("held_frames", dut_done_cnt - d0, 1);
      e = '{8'h30, 8'h30, 8'h30, 8'h37, 8'h2C, 8'h30, 8'h30, 8'h38};
      check_bytes("held", e);

      // second pulse while busy is ignored; pulse right after done accepted
      rx_q.delete();
      d0 = dut_done_cnt;
      pulse(123, 45);
      repeat (300) @(negedge clock);
      x_in = 10'd999; y_in = 9'd1; valid_in = 1'b1;
      @(negedge clock) valid_in = 1'b0;
      wait_done(lat, bc, fl);
      check("busy_ign_lat", lat, LIT_END);
      e = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h2C, 8'h30, 8'h34, 8'h35};
      check_bytes("busy_ign", e);
      rx_q.delete();
      x_in = 10'd5; y_in = 9'd6; valid_in = 1'b1;
      @(negedge clock);
      valid_in = 1'b0;
      start_e  = m_e;
      check("b2b_busy", int'(busy), 1);
      wait_done(lat, bc, fl);
      check("b2b_lat", lat, LIT_END);
      e = '{8'h30, 8'h30, 8'h30, 8'h35, 8'h2C, 8'h30, 8'h30, 8'h36};
      check_bytes("b2b", e);
      repeat (50) @(negedge clock);
      check("b2b_frames", dut_done_cnt - d0, 2);

      // reset during byte 3, data bit 4
      rx_q.delete();
      pulse(640, 480);
      for (int i = 0; i < 2000 && !(m_busy && m_e - start_e == 366); i++)
         @(negedge clock);
      check("mid_reached", m_e - start_e, 366);
      #1 notReset = 1'b0;
      #1;
      check("mid_txd", int'(TxD), 1);
      check("mid_busy", int'(busy), 0);
      check("mid_done", int'(done), 0);
      repeat (3) @(negedge clock);
      notReset = 1'b1;
      repeat (5) @(negedge clock);
      rx_q.delete();
      pulse(1023, 511);
      wait_done(lat, bc, fl);
      check("post_rst_lat", lat, LIT_END);
      e = '{8'h31, 8'h30, 8'h32, 8'h33, 8'h2C, 8'h35, 8'h31, 8'h31};
      check_bytes("post_rst", e);

      repeat (20) @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
